// File: rtl/uart_tx_frame_pkg.sv
// Shared UART Tx definitions: data width, FSM states and line constants.
package parameters_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first shift register with bit counter; head is the bit on the line,
// next_head the bit that follows it after one shift.
module uart_tx_serializer
    import parameters_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             head,
    output logic             next_head,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= data;
            cnt <= '0;
        end else if (shift) begin
            sh  <= {1'b0, sh[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
        end
    end

    assign head      = sh[0];
    assign next_head = sh[1];
    assign done      = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop.
// Outputs are registered with the value of the state being entered.
module uart_tx_frame
    import parameters_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    tx_state_e state_q, state_d;
    logic      tx_q, tx_d;
    logic      busy_q, busy_d;
    logic      pen_q, ptyp_q, dpar_q;
    logic      load, shift;
    logic      head, next_head, done;
    logic      par_bit;

    uart_tx_serializer #(
        .WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk      (CLK),
        .rst      (RST),
        .load     (load),
        .shift    (shift),
        .data     (P_DATA),
        .head     (head),
        .next_head(next_head),
        .done     (done)
    );

    // Data parity is captured at accept since the shifter consumes the word.
    assign par_bit = dpar_q ^ (ptyp_q == PAR_ODD);

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d   = STOP_BIT;
                busy_d = 1'b0;
                if (DATA_VALID) begin
                    state_d = START;
                    tx_d    = START_BIT;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                tx_d    = head;
            end
            DATA: begin
                if (done) begin
                    if (pen_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit;
                    end else begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end
                end else begin
                    shift = 1'b1;
                    tx_d  = next_head;
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = STOP_BIT;
            end
            STOP: begin
                state_d = IDLE;
                tx_d    = STOP_BIT;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                tx_d    = STOP_BIT;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            tx_q    <= STOP_BIT;
            busy_q  <= 1'b0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            dpar_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (load) begin
                pen_q  <= PAR_EN;
                ptyp_q <= PAR_TYP;
                dpar_q <= ^P_DATA;
            end
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: expected line waveforms are
// built from the frame format rules and compared every cycle.
module tb_uart_tx_frame;
  import parameters_pkg::*;

  localparam int DW = DATA_WIDTH;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_OUT;
  logic          BUSY;

  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];

  uart_tx_frame dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic build_frame(input logic [DW-1:0] d,
                             input logic pen,
                             input logic ptyp);
    int ones;
    ones = 0;
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) exp_q.push_back(((ones % 2) == 1) ^ ptyp);
    exp_q.push_back(1'b1);
  endtask

  task automatic check_frame(input string name, input int mode);
    for (int n = 0; n < exp_q.size(); n++) begin
      @(negedge CLK);
      vectors++;
      if (TX_OUT !== exp_q[n] || BUSY !== 1'b1) begin
        miscompares++;
        $display("FAIL %s bit%0d: tx=%b busy=%b, want tx=%b busy=1",
                 name, n, TX_OUT, BUSY, exp_q[n]);
      end
      if (mode == 0 && n == 0) DATA_VALID = 1'b0;
      if (mode == 2) begin
        P_DATA     = DW'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        DATA_VALID = 1'($urandom);
        if (n == exp_q.size() - 1) DATA_VALID = 1'b0;
      end
      if (mode == 3) begin
        if (n == 0) DATA_VALID = 1'b0;
        if (n == 2) P_DATA = 8'h00;
        if (n == 3 || n == 10) begin
          DATA_VALID = 1'b1;
          P_DATA     = 8'hFF;
        end
        if (n == 4) DATA_VALID = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge CLK);
      vectors++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL %s idle%0d: tx=%b busy=%b, want tx=1 busy=0",
                 name, n, TX_OUT, BUSY);
      end
      DATA_VALID = 1'b0;
    end
  endtask

  task automatic start(input logic [DW-1:0] d,
                       input logic pen,
                       input logic ptyp);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    DATA_VALID = 1'b1;
    build_frame(d, pen, ptyp);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    DATA_VALID = 1'b1;
    repeat (2) @(negedge CLK);
    vectors++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: tx=%b busy=%b, want tx=1 busy=0",
               TX_OUT, BUSY);
    end
    RST = 1'b0;
    DATA_VALID = 1'b0;
    check_idle("post_reset", 2);
  endtask

  task automatic test_directed();
    start(8'hA5, 1'b1, 1'b0);
    check_frame("a5_even", 0);
    check_idle("a5_even", 2);
    start(8'hA5, 1'b1, 1'b1);
    check_frame("a5_odd", 0);
    check_idle("a5_odd", 1);
    start(8'h3C, 1'b0, 1'b0);
    check_frame("3c_nopar", 0);
    check_idle("3c_nopar", 1);
  endtask

  task automatic test_ignore();
    start(8'h81, 1'b1, 1'b0);
    check_frame("ignore_81", 3);
    check_idle("ignore_81", 4);
  endtask

  task automatic test_reset_mid();
    start(8'hF0, 1'b1, 1'b0);
    for (int n = 0; n <= 5; n++) begin
      @(negedge CLK);
      vectors++;
      if (TX_OUT !== exp_q[n] || BUSY !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_mid bit%0d: tx=%b busy=%b, want tx=%b busy=1",
                 n, TX_OUT, BUSY, exp_q[n]);
      end
      if (n == 0) DATA_VALID = 1'b0;
    end
    RST = 1'b1;
    @(negedge CLK);
    vectors++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid abort: tx=%b busy=%b, want tx=1 busy=0",
               TX_OUT, BUSY);
    end
    RST = 1'b0;
    start(8'h55, 1'b1, 1'b0);
    check_frame("after_reset_55", 0);
    check_idle("after_reset_55", 1);
  endtask

  task automatic test_back_to_back();
    start(8'h01, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) begin
      check_frame("b2b", 1);
      if (f == 2) DATA_VALID = 1'b0;
      @(negedge CLK);
      vectors++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b gap%0d: tx=%b busy=%b, want tx=1 busy=0",
                 f, TX_OUT, BUSY);
      end
    end
    check_idle("b2b_end", 2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      start(DW'($urandom), 1'($urandom), 1'($urandom));
      check_frame("random", 2);
      check_idle("random", 1 + int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter for the Tx side of the UART link, mirroring the Rx parity check and deserializer path. Accepts a parallel byte with a one-cycle valid strobe and latches it with the parity configuration. Serializes the byte as start, data LSB-first, optional parity, stop. Runs in the Tx clock domain at one bit per CLK cycle; CLK is the already-divided baud clock.

Parameters:
DATA_WIDTH, 8 (from parameters_pkg), width of the parallel data word and number of data bits per frame

Ports:
CLK  input  1  Tx baud clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel data to send; sampled only on accept
DATA_VALID  input  1  request to send P_DATA; sampled only in IDLE
PAR_EN  input  1  1 = insert parity bit; sampled on accept
PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept
TX_OUT  output  1  serial line, registered; idles high
BUSY  output  1  registered; high while a frame is on the line

Behaviour:
- Reset: RST=1 at a rising edge forces IDLE, TX_OUT=1, BUSY=0, shift register=0, bit counter=0, latched config=0.
- Reset mid-frame: the frame is abandoned at that same edge. No partial stop bit is sent. The line returns high immediately.
- States: IDLE, START, DATA, PARITY, STOP (tx_state_e).
- IDLE: TX_OUT=1, BUSY=0.
  - DATA_VALID=1 at edge k is the accept. At edge k: latch P_DATA, PAR_EN and PAR_TYP; go to START; drive TX_OUT<=0 and BUSY<=1.
- START: one cycle, then DATA.
- DATA: DATA_WIDTH cycles. Data bit i is on TX_OUT during cycle k+1+i, LSB first. The counter runs 0..DATA_WIDTH-1.
  - After the last bit: go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY: one cycle.
  - Even (PAR_TYP=0): TX_OUT = XOR-reduce of the latched data.
  - Odd (PAR_TYP=1): TX_OUT = its inverse.
  - This is the same rule the Rx checker applies.
- STOP: one cycle with TX_OUT=1. At the next edge go to IDLE with BUSY<=0.
- Frame length: DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without. BUSY is high for exactly that many cycles.
- DATA_VALID is ignored in every state other than IDLE, including STOP; there is no queuing.
  - Minimum start-to-start spacing is frame length + 1 (at least one idle-high cycle).
- Input changes after accept do not affect the frame in flight. This covers P_DATA, PAR_EN and PAR_TYP.
- TX_OUT and BUSY come straight from flops; there is no combinational path from inputs to outputs.
- The counter width is $clog2(DATA_WIDTH). It is compared against DATA_WIDTH-1 and never wraps past it.

Decomposition:
- parameters_pkg: DATA_WIDTH (existing); tx_state_e enum; PAR_EVEN=1'b0 and PAR_ODD=1'b1; START_BIT=1'b0 and STOP_BIT=1'b1.
- Sub-module uart_tx_serializer: load, shift enable, DATA_WIDTH shift register, bit counter and done flag.
- The top holds the FSM, parity computation and output mux.

Test Plan:
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, single-cycle DATA_VALID -> TX_OUT over 11 cycles: 0,1,0,1,0,0,1,0,1,0,1; BUSY high exactly 11 cycles; then TX_OUT=1.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> parity cycle TX_OUT=1; full frame 0,1,0,1,0,0,1,0,1,1,1.
- P_DATA=0x3C, PAR_EN=0 -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1; no parity cycle; BUSY high 10 cycles.
- Accept 0x81, then pulse DATA_VALID with 0xFF at cycles 3 and 10 of the frame, and change P_DATA to 0x00 at cycle 2 -> frame carries 0x81 unchanged; no second frame starts; BUSY falls on schedule.
- RST=1 during DATA bit 4 of 0xF0 -> at that edge TX_OUT=1 and BUSY=0; a new accept of 0x55 on the next cycle yields a clean complete frame.
- DATA_VALID held high continuously with 0x01, PAR_EN=1 even -> frames repeat with exactly one idle-high cycle between stop and the next start; parity bit=1 in each.
